// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control FSM for the MIPS datapath (PC, IM/IR, GRF,
// EXT, ALU, DM, NPC). Sequences each instruction through IF/ID/EX/MEM/WB,
// drives every write enable and mux select, stalls in MEM on the DM ready
// handshake and counts retired instructions.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   op, func            IR[31:26], IR[5:0] fed back from the datapath
//   zero                ALU equal flag (used in EX for BEQ)
//   mem_ready           DM access complete (used in MEM only)
//   ir_write, pc_write, reg_write, mem_req, mem_we   enables
//   alusrc, aluctr, regdst, memtoreg, extop, npc_sel selects
//   state               current phase (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   retire, retired     completion pulse and retired-instruction count
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | fetch: load IR from IM
// ID    | decode: class latched; J/JR/NOP finish here
// EX    | ALU operation; BEQ finishes here
// MEM   | DM access, held until mem_ready; SW finishes here
// WB    | GRF write-back and PC update

module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             alusrc,
    output logic [2:0]       aluctr,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic [1:0]       extop,
    output logic [1:0]       npc_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_ADDU = 4'd1;
    localparam logic [3:0] C_SUBU = 4'd2;
    localparam logic [3:0] C_JR   = 4'd3;
    localparam logic [3:0] C_ORI  = 4'd4;
    localparam logic [3:0] C_LUI  = 4'd5;
    localparam logic [3:0] C_LW   = 4'd6;
    localparam logic [3:0] C_SW   = 4'd7;
    localparam logic [3:0] C_BEQ  = 4'd8;
    localparam logic [3:0] C_JAL  = 4'd9;
    localparam logic [3:0] C_J    = 4'd10;

    logic [2:0]       r_state;
    logic [3:0]       r_cls;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_dec;
    logic [2:0]       w_next;
    logic             w_retire;

    always_comb begin
        w_dec = C_NOP;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100001: w_dec = C_ADDU;
                    6'b100011: w_dec = C_SUBU;
                    6'b001000: w_dec = C_JR;
                    default:   w_dec = C_NOP;
                endcase
            end
            6'b001101: w_dec = C_ORI;
            6'b001111: w_dec = C_LUI;
            6'b100011: w_dec = C_LW;
            6'b101011: w_dec = C_SW;
            6'b000100: w_dec = C_BEQ;
            6'b000011: w_dec = C_JAL;
            6'b000010: w_dec = C_J;
            default:   w_dec = C_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IF;
            r_cls     <= C_NOP;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID)
                r_cls <= w_dec;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alusrc    = 1'b0;
        aluctr    = 3'd0;
        regdst    = 2'd0;
        memtoreg  = 2'd0;
        extop     = 2'd0;
        npc_sel   = 2'd0;

        // ALU/EXT selects are held from EX to the end of the instruction so
        // aluout stays valid for the DM address and the write-back value.
        if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
            case (r_cls)
                C_SUBU, C_BEQ: aluctr = 3'd1;
                C_ORI:  begin aluctr = 3'd2; alusrc = 1'b1; extop = 2'd0; end
                C_LUI:  begin aluctr = 3'd2; alusrc = 1'b1; extop = 2'd2; end
                C_LW, C_SW: begin alusrc = 1'b1; extop = 2'd1; end
                default: aluctr = 3'd0;
            endcase
        end

        case (r_state)
            S_IF: begin
                ir_write = 1'b1;
                w_next   = S_ID;
            end
            S_ID: begin
                case (w_dec)
                    C_J:   begin w_retire = 1'b1; npc_sel = 2'd2; w_next = S_IF; end
                    C_JR:  begin w_retire = 1'b1; npc_sel = 2'd3; w_next = S_IF; end
                    C_NOP: begin w_retire = 1'b1; npc_sel = 2'd0; w_next = S_IF; end
                    C_JAL: w_next = S_WB;
                    default: w_next = S_EX;
                endcase
            end
            S_EX: begin
                if (r_cls == C_BEQ) begin
                    w_retire = 1'b1;
                    npc_sel  = zero ? 2'd1 : 2'd0;
                    w_next   = S_IF;
                end else if (r_cls == C_LW || r_cls == C_SW) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_cls == C_SW);
                if (mem_ready) begin
                    if (r_cls == C_SW) begin
                        w_retire = 1'b1;
                        w_next   = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_IF;
                case (r_cls)
                    C_ADDU, C_SUBU: regdst = 2'd1;
                    C_LW:           memtoreg = 2'd1;
                    C_JAL: begin regdst = 2'd2; memtoreg = 2'd2; npc_sel = 2'd2; end
                    default:        regdst = 2'd0;
                endcase
            end
            default: w_next = S_IF;
        endcase

        // PC is only ever loaded on the cycle the instruction retires.
        pc_write = w_retire;

        // Reset forces all enables and selects low immediately, even though
        // the state register already reads IF (which would raise ir_write).
        if (reset) begin
            w_retire  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            alusrc    = 1'b0;
            aluctr    = 3'd0;
            regdst    = 2'd0;
            memtoreg  = 2'd0;
            extop     = 2'd0;
            npc_sel   = 2'd0;
        end
    end

    assign state   = r_state;
    assign retire  = w_retire;
    assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed instruction stream, per-cycle comparison
// of all outputs against a phase-level model of each instruction class.
module tb_mc_ctrl;

    localparam int CW = 4;

    localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4,
                   K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9, K_J = 10;
    localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    op, func;
    logic          zero, mem_ready;
    logic          ir_write, pc_write, reg_write, mem_req, mem_we, alusrc, retire;
    logic [2:0]    aluctr, state;
    logic [1:0]    regdst, memtoreg, extop, npc_sel;
    logic [CW-1:0] retired;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
        .alusrc(alusrc), .aluctr(aluctr), .regdst(regdst), .memtoreg(memtoreg),
        .extop(extop), .npc_sel(npc_sel), .state(state), .retire(retire),
        .retired(retired)
    );

    always #5 clk = ~clk;

    logic [20:0] dut_v;
    assign dut_v = {state, ir_write, pc_write, reg_write, mem_req, mem_we, alusrc,
                    aluctr, regdst, memtoreg, extop, npc_sel, retire};

    typedef struct {
        logic [20:0]   v;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] m_cnt = '0;

    function automatic int cls_of(logic [5:0] o, logic [5:0] f);
        if (o == 6'd0) begin
            if (f == 6'b100001) return K_ADDU;
            if (f == 6'b100011) return K_SUBU;
            if (f == 6'b001000) return K_JR;
            return K_NOP;
        end
        case (o)
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000011: return K_JAL;
            6'b000010: return K_J;
            default:   return K_NOP;
        endcase
    endfunction

    // Expected outputs for one cycle of an instruction of class k in phase ph.
    function automatic logic [20:0] exp_vec(int k, int ph, logic z, bit mem_done);
        logic [2:0] st, alu;
        logic       irw, pcw, rw, mr, mw, asrc, ret;
        logic [1:0] rd, m2r, ext, npc;
        st = 3'(ph);
        {irw, pcw, rw, mr, mw, asrc, ret} = '0;
        alu = 3'd0; rd = 2'd0; m2r = 2'd0; ext = 2'd0; npc = 2'd0;
        if (ph >= P_EX) begin
            if (k == K_SUBU || k == K_BEQ) alu = 3'd1;
            if (k == K_ORI) begin alu = 3'd2; asrc = 1'b1; ext = 2'd0; end
            if (k == K_LUI) begin alu = 3'd2; asrc = 1'b1; ext = 2'd2; end
            if (k == K_LW || k == K_SW) begin asrc = 1'b1; ext = 2'd1; end
        end
        if (ph == P_IF) irw = 1'b1;
        if (ph == P_ID && (k == K_J || k == K_JR || k == K_NOP)) begin
            ret = 1'b1;
            npc = (k == K_J) ? 2'd2 : (k == K_JR) ? 2'd3 : 2'd0;
        end
        if (ph == P_EX && k == K_BEQ) begin
            ret = 1'b1;
            npc = z ? 2'd1 : 2'd0;
        end
        if (ph == P_MEM) begin
            mr = 1'b1;
            mw = (k == K_SW);
            if (mem_done && k == K_SW) ret = 1'b1;
        end
        if (ph == P_WB) begin
            rw = 1'b1; ret = 1'b1;
            if (k == K_ADDU || k == K_SUBU) rd = 2'd1;
            if (k == K_LW) m2r = 2'd1;
            if (k == K_JAL) begin rd = 2'd2; m2r = 2'd2; npc = 2'd2; end
        end
        pcw = ret;
        return {st, irw, pcw, rw, mr, mw, asrc, alu, rd, m2r, ext, npc, ret};
    endfunction

    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (dut_v !== e.v || retired !== e.cnt) begin
                errors++;
                $display("FAIL cycle t=%0t: outputs got %h expected %h, retired got %0d expected %0d",
                         $time, dut_v, e.v, retired, e.cnt);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction; called just after a rising edge with the DUT in IF.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int stalls, output int ncyc);
        int ph[$];
        int k, m;
        exp_t e;
        k = cls_of(o, f);
        ph.push_back(P_IF);
        ph.push_back(P_ID);
        if (!(k == K_J || k == K_JR || k == K_NOP || k == K_JAL)) ph.push_back(P_EX);
        if (k == K_LW || k == K_SW)
            for (int i = 0; i <= stalls; i++) ph.push_back(P_MEM);
        if (!(k == K_J || k == K_JR || k == K_NOP || k == K_BEQ || k == K_SW))
            ph.push_back(P_WB);
        ncyc = ph.size();
        m = 0;
        foreach (ph[i]) begin
            op = o; func = f; zero = z;
            mem_ready = (ph[i] == P_MEM) ? (m == stalls) : 1'b1;
            e.v   = exp_vec(k, ph[i], z, (ph[i] == P_MEM) && (m == stalls));
            e.cnt = m_cnt;
            q.push_back(e);
            if (e.v[0]) m_cnt = m_cnt + 1'b1;
            if (ph[i] == P_MEM) m++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        exp_t e;
        reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        check_lit("reset_outputs", {11'd0, dut_v}, 32'd0);
        check_lit("reset_retired", {28'd0, retired}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run(6'b000000, 6'b100001, 1'b0, 0, n);
        check_lit("addu_cycles", n, 4);
        check_lit("addu_retired", {28'd0, retired}, 32'd1);
        run(6'b000000, 6'b100011, 1'b1, 0, n);
        run(6'b100011, 6'b000000, 1'b0, 2, n);
        check_lit("lw_cycles", n, 7);
        run(6'b101011, 6'b000000, 1'b0, 1, n);
        check_lit("sw_cycles", n, 5);
        run(6'b000100, 6'b000000, 1'b1, 0, n);
        check_lit("beq_cycles", n, 3);
        run(6'b000100, 6'b000000, 1'b0, 0, n);
        run(6'b000011, 6'b000000, 1'b0, 0, n);
        check_lit("jal_cycles", n, 3);
        run(6'b000000, 6'b001000, 1'b0, 0, n);
        check_lit("jr_cycles", n, 2);
        run(6'b000010, 6'b000000, 1'b0, 0, n);
        run(6'b111111, 6'b000000, 1'b0, 0, n);
        check_lit("illegal_cycles", n, 2);
        run(6'b001101, 6'b000000, 1'b0, 0, n);
        run(6'b001111, 6'b000000, 1'b0, 0, n);
        run(6'b000000, 6'b111111, 1'b0, 0, n);
        check_lit("retired_13", {28'd0, retired}, 32'd13);
        for (int i = 0; i < 6; i++)
            run((i % 2 == 0) ? 6'b000010 : 6'b010101, 6'b000000, 1'b0, 0, n);
        check_lit("retired_wrap", {28'd0, retired}, 32'd3);

        // SW aborted by reset while stalled in MEM
        op = 6'b101011; func = '0; zero = 1'b0; mem_ready = 1'b1;
        for (int p = P_IF; p <= P_MEM; p++) begin
            if (p == P_MEM) mem_ready = 1'b0;
            e.v = exp_vec(K_SW, p, 1'b0, 1'b0);
            e.cnt = m_cnt;
            q.push_back(e);
            if (p != P_MEM) begin @(posedge clk); #1; end
        end
        @(negedge clk); #2;
        check_lit("mem_stall_state", {29'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        check_lit("abort_outputs", {11'd0, dut_v}, 32'd0);
        check_lit("abort_retired", {28'd0, retired}, 32'd0);
        m_cnt = '0;
        q.delete();
        @(posedge clk); #1;
        check_lit("held_reset_outputs", {11'd0, dut_v}, 32'd0);
        reset = 1'b0;
        run(6'b001101, 6'b000000, 1'b0, 0, n);
        check_lit("ori_after_reset", {28'd0, retired}, 32'd1);

        @(negedge clk);
        check_lit("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS datapath: PC, IM/IR, GRF, EXT, ALU, DM and NPC, with the datapath's existing mux encodings.
- Sequences each instruction through IF/ID/EX/MEM/WB and drives all write enables and mux selects.
- Stalls in MEM on a DM ready handshake.
- Counts retired instructions.
- Sits beside the datapath; the datapath's IR feeds op/func/zero back.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; forces state and outputs to reset values immediately
op  in  6  IR[31:26]; valid from ID until instruction end (IR held)
func  in  6  IR[5:0]; same validity as op
zero  in  1  ALU equal flag; sampled in EX only
mem_ready  in  1  DM access complete this cycle
ir_write  out  1  load IR from IM
pc_write  out  1  load PC from NPC
reg_write  out  1  GRF write enable
mem_req  out  1  DM access request
mem_we  out  1  DM write (only with mem_req)
alusrc  out  1  0 read2, 1 extout
aluctr  out  3  0 add, 1 sub, 2 or
regdst  out  2  0 rt, 1 rd, 2 $31
memtoreg  out  2  0 aluout, 1 memout, 2 pc+4
extop  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
npc_sel  out  2  0 pc+4, 1 branch target, 2 j/jal target, 3 read1
state  out  3  IF=0 ID=1 EX=2 MEM=3 WB=4
retire  out  1  one-cycle pulse when instruction completes
retired  out  CNT_W  retired instruction count

Behaviour:
- Reset values: state=IF, retired=0, class register=NOP; every output enable 0; selects 0.
  - While reset is high all enables are forced 0, including ir_write.
- Decode, in ID only; class latched at the ID->next edge. Later states use the latched class:
  - op=000000: func 100001 ADDU, 100011 SUBU, 001000 JR.
  - op 001101 ORI, 001111 LUI, 100011 LW, 101011 SW, 000100 BEQ, 000011 JAL, 000010 J.
  - Anything else is NOP; no architectural effect except PC+4.
- IF: ir_write=1. Next state ID.
- ID:
  - J, JR, NOP: pc_write=1 with npc_sel 2, 3 and 0 respectively; retire; next state IF.
  - JAL: next state WB.
  - All other classes: next state EX.
- EX: aluctr, alusrc and extop held per class.
  - ADDU: add, alusrc 0. SUBU: sub, alusrc 0. ORI: or, alusrc 1, extop 0. LUI: or with $0 source, alusrc 1, extop 2.
  - LW/SW: add, alusrc 1, extop 1.
  - BEQ: sub, alusrc 0; pc_write=1, npc_sel=1 if zero else 0; retire; next state IF.
  - LW/SW: next state MEM. All others: next state WB.
  - EX selects stay stable through MEM/WB so aluout remains valid.
- MEM: mem_req=1; mem_we=1 for SW.
  - Stay in MEM while mem_ready=0; selects and mem_we are held.
  - On mem_ready=1, SW: pc_write=1, npc_sel=0, retire, next state IF. LW: next state WB.
  - mem_ready is ignored outside MEM.
- WB: reg_write=1, pc_write=1, retire, next state IF. Write-back selects per class:
  - ADDU/SUBU: regdst 1, memtoreg 0.
  - ORI/LUI: regdst 0, memtoreg 0.
  - LW: regdst 0, memtoreg 1.
  - JAL: regdst 2, memtoreg 2, npc_sel 2. All others in WB: npc_sel 0.
- Exactly one pc_write per instruction, always in the final cycle, so PC and pc+4 stay stable throughout.
- Cycles per instruction:
  - J/JR/NOP 2; BEQ 3; JAL 3; ADDU/SUBU/ORI/LUI 4; SW 4+stall; LW 5+stall.
- Counter: retired increments on each retire cycle; wraps from all-ones to 0.
- Output timing: outputs are combinational from state and class only. zero and mem_ready are the exceptions, affecting pc_write/npc_sel and state transition respectively.
- Reset mid-instruction, including a MEM stall: immediate abort, no reg_write/mem_we/pc_write pulse; after release, IF.

Test Plan:
- Reset, then ADDU (op 0, func 100001) -> states 0,1,2,4; reg_write=1, regdst=1 only in WB; pc_write once in WB; retired=1.
- LW with mem_ready low for 2 MEM cycles -> MEM held 3 cycles with mem_req=1, mem_we=0; WB memtoreg=1; 7 cycles total.
- BEQ, zero=1 then zero=0 -> 3 cycles each; npc_sel=1 then 0 at EX pc_write; reg_write never 1.
- JAL then JR -> JAL: WB regdst=2, memtoreg=2, npc_sel=2. JR: ID pc_write with npc_sel=3, 2 cycles.
- Illegal op 111111 -> 2 cycles, npc_sel=0, no reg_write/mem_req; retire pulses.
- SW with reset asserted mid-MEM -> mem_we and all enables drop to 0 asynchronously; state=0, retired=0 after release; then an ORI completes normally.
